event_summary: RTL and testbench

//  Downstream of the event detector and the DFSWT frequency-bin smoother.
//  Per detected event (eventDetected high run), measures duration, mean and peak freqbin.

---
 rtl/event_summary.sv | 257 +++++++++++++++++++++++++
 tb/tb_event_summary.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/event_summary.sv
// event_summary
//   Measures each detected event (a run of event_in high) and queues one
//   summary record per event of at least MIN_LEN samples. A record holds the
//   duration, the floored mean and the peak freqbin, plus a flag that is set
//   when the duration counter saturated. Records leave through a small
//   first-word-fall-through FIFO with a valid/ready handshake.
//
//   Ports
//     clock            system clock, posedge
//     reset            asynchronous reset, active low
//     event_in         event detector output, sampled every edge
//     freqbin          smoothed bin, meaningful while event_in is high
//     rec_valid        FIFO head holds a record
//     rec_ready        consumer accepts the head when rec_valid is high
//     rec_duration     event length in samples (saturated)
//     rec_bin_avg      floor(sum(freqbin) / duration)
//     rec_bin_peak     largest freqbin seen during the event
//     rec_sat          duration saturated during the event
//     drop_count       records lost to a full FIFO, saturates at 255
//     rec_timestamp    (only with EVSUM_TIMESTAMP_EN) free-running counter
//                      value at the edge that entered ACTIVE
//
//   Build option: define EVSUM_TIMESTAMP_EN to add the timestamp counter and
//   the rec_timestamp port.
//
//   state  | meaning
//   IDLE   | waiting for a fresh 0->1 edge on event_in
//   ACTIVE | accumulating duration, sum and peak
//   DIVIDE | restoring divide sum/duration, one quotient bit per cycle
//   PUSH   | write record into FIFO, or count a drop if it is full

module event_summary #(
    parameter int BIN_W   = 6,
    parameter int DUR_W   = 16,
    parameter int MIN_LEN = 4,
    parameter int FIFO_AW = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             event_in,
    input  logic [BIN_W-1:0] freqbin,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [DUR_W-1:0] rec_duration,
    output logic [BIN_W-1:0] rec_bin_avg,
    output logic [BIN_W-1:0] rec_bin_peak,
    output logic             rec_sat,
    output logic [7:0]       drop_count
`ifdef EVSUM_TIMESTAMP_EN
    ,
    output logic [31:0]      rec_timestamp
`endif
);

    localparam int SUM_W = DUR_W + BIN_W;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DIVIDE, S_PUSH} state_t;

    state_t             state_q, state_d;
    logic               prev_q;
    logic [DUR_W-1:0]   dur_q, dur_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [BIN_W-1:0]   pk_q, pk_d;
    logic               sat_q, sat_d;
    logic [SUM_W-1:0]   rem_q, rem_d;
    logic [SUM_W-1:0]   dsr_q, dsr_d;
    logic [BIN_W-1:0]   quo_q, quo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         drop_q;
    logic               push_en;
    logic               rise;

    logic [FIFO_AW:0]   wptr_q, rptr_q;
    logic [DUR_W-1:0]   mem_dur  [DEPTH];
    logic [BIN_W-1:0]   mem_avg  [DEPTH];
    logic [BIN_W-1:0]   mem_pk   [DEPTH];
    logic               mem_sat  [DEPTH];
    logic               fifo_empty, fifo_full, do_push, do_pop;
    logic [FIFO_AW-1:0] head_idx;

`ifdef EVSUM_TIMESTAMP_EN
    logic [31:0]        ts_q;
    logic [31:0]        ts_start_q, ts_start_d;
    logic [31:0]        mem_ts   [DEPTH];
`endif

    assign rise = event_in && !prev_q;

    // state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (rise) state_d = S_ACTIVE;
            S_ACTIVE: if (!event_in) state_d = (dur_q >= DUR_W'(MIN_LEN)) ? S_DIVIDE : S_IDLE;
            S_DIVIDE: if (cnt_q == '0) state_d = S_PUSH;
            S_PUSH:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // datapath next values and FIFO write request
    always_comb begin
        dur_d   = dur_q;
        sum_d   = sum_q;
        pk_d    = pk_q;
        sat_d   = sat_q;
        rem_d   = rem_q;
        dsr_d   = dsr_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        push_en = 1'b0;
`ifdef EVSUM_TIMESTAMP_EN
        ts_start_d = ts_start_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    dur_d = DUR_W'(1);
                    sum_d = SUM_W'(freqbin);
                    pk_d  = freqbin;
                    sat_d = 1'b0;
`ifdef EVSUM_TIMESTAMP_EN
                    // counter value as it stands after this edge
                    ts_start_d = ts_q + 32'd1;
`endif
                end
            end
            S_ACTIVE: begin
                if (event_in) begin
                    // sum only grows with duration so the average stays exact
                    if (dur_q != '1) begin
                        dur_d = dur_q + DUR_W'(1);
                        sum_d = sum_q + SUM_W'(freqbin);
                    end else begin
                        sat_d = 1'b1;
                    end
                    if (freqbin > pk_q) pk_d = freqbin;
                end else begin
                    // quotient < 2^BIN_W, so the divisor starts at dur << (BIN_W-1)
                    rem_d = sum_q;
                    dsr_d = SUM_W'(dur_q) << (BIN_W - 1);
                    quo_d = '0;
                    cnt_d = CNT_W'(BIN_W - 1);
                end
            end
            S_DIVIDE: begin
                if (rem_q >= dsr_q) begin
                    rem_d = rem_q - dsr_q;
                    quo_d = BIN_W'({quo_q, 1'b1});
                end else begin
                    quo_d = BIN_W'({quo_q, 1'b0});
                end
                dsr_d = dsr_q >> 1;
                if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            end
            S_PUSH: push_en = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_q <= 1'b0;
            dur_q  <= '0;
            sum_q  <= '0;
            pk_q   <= '0;
            sat_q  <= 1'b0;
            rem_q  <= '0;
            dsr_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
        end else begin
            prev_q <= event_in;
            dur_q  <= dur_d;
            sum_q  <= sum_d;
            pk_q   <= pk_d;
            sat_q  <= sat_d;
            rem_q  <= rem_d;
            dsr_q  <= dsr_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_d;
        end
    end

    // record FIFO; a full FIFO refuses a push even if the head pops this cycle
    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                        (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
    assign do_push    = push_en && !fifo_full;
    assign do_pop     = rec_valid && rec_ready;

    // when empty, show the slot just popped so the outputs hold the last head
    assign head_idx = fifo_empty ? (rptr_q[FIFO_AW-1:0] - FIFO_AW'(1))
                                 : rptr_q[FIFO_AW-1:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            drop_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_dur[i] <= '0;
                mem_avg[i] <= '0;
                mem_pk[i]  <= '0;
                mem_sat[i] <= 1'b0;
`ifdef EVSUM_TIMESTAMP_EN
                mem_ts[i]  <= '0;
`endif
            end
        end else begin
            if (do_push) begin
                mem_dur[wptr_q[FIFO_AW-1:0]] <= dur_q;
                mem_avg[wptr_q[FIFO_AW-1:0]] <= quo_q;
                mem_pk[wptr_q[FIFO_AW-1:0]]  <= pk_q;
                mem_sat[wptr_q[FIFO_AW-1:0]] <= sat_q;
`ifdef EVSUM_TIMESTAMP_EN
                mem_ts[wptr_q[FIFO_AW-1:0]]  <= ts_start_q;
`endif
                wptr_q <= wptr_q + (FIFO_AW+1)'(1);
            end
            if (push_en && fifo_full && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
            if (do_pop) rptr_q <= rptr_q + (FIFO_AW+1)'(1);
        end
    end

`ifdef EVSUM_TIMESTAMP_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ts_q       <= '0;
            ts_start_q <= '0;
        end else begin
            ts_q       <= ts_q + 32'd1;
            ts_start_q <= ts_start_d;
        end
    end
    assign rec_timestamp = mem_ts[head_idx];
`endif

    assign rec_valid    = !fifo_empty;
    assign rec_duration = mem_dur[head_idx];
    assign rec_bin_avg  = mem_avg[head_idx];
    assign rec_bin_peak = mem_pk[head_idx];
    assign rec_sat      = mem_sat[head_idx];
    assign drop_count   = drop_q;

endmodule

// File: tb/tb_event_summary.sv
module tb_event_summary;

    typedef struct {
        int dur;
        int avg;
        int pk;
        int sat;
        int ts;
    } rec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        event_in = 1'b0;
    logic [5:0]  freqbin = '0;
    logic        rec_ready = 1'b0;
    logic        rec_valid;
    logic [15:0] rec_duration;
    logic [5:0]  rec_bin_avg, rec_bin_peak;
    logic        rec_sat;
    logic [7:0]  drop_count;

    logic        ev2 = 1'b0;
    logic [5:0]  fb2 = '0;
    logic        rdy2 = 1'b1;
    logic        rv2;
    logic [3:0]  dur2;
    logic [5:0]  avg2, pk2;
    logic        sat2;
    logic [7:0]  drop2;

`ifdef EVSUM_TIMESTAMP_EN
    logic [31:0] rec_timestamp, ts2;
`endif

    rec_t q1[$];
    rec_t q2[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clock = ~clock;

    event_summary dut (
        .clock(clock), .reset(reset), .event_in(event_in), .freqbin(freqbin),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_duration(rec_duration),
        .rec_bin_avg(rec_bin_avg), .rec_bin_peak(rec_bin_peak), .rec_sat(rec_sat),
        .drop_count(drop_count)
`ifdef EVSUM_TIMESTAMP_EN
        , .rec_timestamp(rec_timestamp)
`endif
    );

    event_summary #(.DUR_W(4)) dut2 (
        .clock(clock), .reset(reset), .event_in(ev2), .freqbin(fb2),
        .rec_valid(rv2), .rec_ready(rdy2), .rec_duration(dur2),
        .rec_bin_avg(avg2), .rec_bin_peak(pk2), .rec_sat(sat2),
        .drop_count(drop2)
`ifdef EVSUM_TIMESTAMP_EN
        , .rec_timestamp(ts2)
`endif
    );

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic rec_t mk(int dur, int avg, int pk, int sat);
        rec_t r;
        r.dur = dur; r.avg = avg; r.pk = pk; r.sat = sat; r.ts = -1;
        return r;
    endfunction

    // monitors: compare every record the DUTs hand over
    always @(negedge clock) begin
        if (reset && rec_valid && rec_ready) begin
            if (q1.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_record: got dur %0d, expected no record", rec_duration);
            end else begin
                rec_t e;
                e = q1.pop_front();
                check("rec_duration", int'(rec_duration), e.dur);
                check("rec_bin_avg",  int'(rec_bin_avg),  e.avg);
                check("rec_bin_peak", int'(rec_bin_peak), e.pk);
                check("rec_sat",      int'(rec_sat),      e.sat);
`ifdef EVSUM_TIMESTAMP_EN
                if (e.ts >= 0) check("rec_timestamp", int'(rec_timestamp), e.ts);
`endif
            end
        end
    end

    always @(negedge clock) begin
        if (reset && rv2 && rdy2) begin
            if (q2.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_record2: got dur %0d, expected no record", dur2);
            end else begin
                rec_t e;
                e = q2.pop_front();
                check("dut2_duration", int'(dur2), e.dur);
                check("dut2_bin_avg",  int'(avg2), e.avg);
                check("dut2_bin_peak", int'(pk2),  e.pk);
                check("dut2_sat",      int'(sat2), e.sat);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // drives one event of len samples: freqbin = (base + step*i) mod 64
    task automatic run_event(input int sel, input int len, input int base, input int step);
        for (int i = 0; i < len; i++) begin
            if (sel == 0) begin
                event_in = 1'b1;
                freqbin  = 6'((base + step * i) % 64);
            end else begin
                ev2 = 1'b1;
                fb2 = 6'((base + step * i) % 64);
            end
            tick(1);
        end
        event_in = 1'b0;
        freqbin  = '0;
        ev2      = 1'b0;
        fb2      = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;

        // reset values
        tick(3);
        check("reset_rec_valid", int'(rec_valid), 0);
        check("reset_rec_duration", int'(rec_duration), 0);
        check("reset_drop_count", int'(drop_count), 0);
        reset = 1'b1;
        tick(2);

        // 10 samples at bin 12
        rec_ready = 1'b1;
        q1.push_back(mk(10, 12, 12, 0));
        run_event(0, 10, 12, 0);
        tick(12);

        // 3 samples: below MIN_LEN, no record
        run_event(0, 3, 20, 0);
        tick(12);
        check("short_rec_valid", int'(rec_valid), 0);
        check("short_drop_count", int'(drop_count), 0);

        // ramp 0..7 with latency check
        q1.push_back(mk(8, 3, 7, 0));
        run_event(0, 8, 0, 1);
        @(posedge clock);
        n = 0;
        while (n < 40) begin
            @(posedge clock);
            #1;
            n++;
            if (rec_valid) break;
        end
        check("latency_edges", n, 7);
        tick(10);

        // exactly MIN_LEN samples with wraparound bins 63,0,1,2
        q1.push_back(mk(4, 16, 63, 0));
        run_event(0, 4, 63, 1);
        tick(12);

        // all-max bins
        q1.push_back(mk(5, 63, 63, 0));
        run_event(0, 5, 63, 0);
        tick(12);

        // consumer stalled: 4 queued, fifth dropped
        rec_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) q1.push_back(mk(4 + i, i + 1, i + 1, 0));
            run_event(0, 4 + i, i + 1, 0);
            tick(12);
        end
        check("full_drop_count", int'(drop_count), 1);
        check("full_rec_valid", int'(rec_valid), 1);
        check("full_head_duration", int'(rec_duration), 4);
        rec_ready = 1'b1;
        tick(10);
        check("drain_pending", q1.size(), 0);
        check("drain_rec_valid", int'(rec_valid), 0);
        check("hold_last_duration", int'(rec_duration), 7);
        check("hold_last_peak", int'(rec_bin_peak), 4);

        // reset in the middle of an event
        event_in = 1'b1;
        freqbin  = 6'd30;
        tick(5);
        #2;
        reset = 1'b0;
        #1;
        check("midreset_rec_duration", int'(rec_duration), 0);
        check("midreset_rec_bin_peak", int'(rec_bin_peak), 0);
        check("midreset_drop_count", int'(drop_count), 0);
        check("midreset_rec_valid", int'(rec_valid), 0);
        event_in = 1'b0;
        freqbin  = '0;
        tick(1);
        reset = 1'b1;
        tick(20);
        check("postreset_rec_valid", int'(rec_valid), 0);

        // event_in re-rises during DIVIDE and stays high past PUSH
        q1.push_back(mk(6, 9, 9, 0));
        run_event(0, 6, 9, 0);
        tick(1);
        run_event(0, 15, 20, 0);
        tick(12);
        check("held_high_pending", q1.size(), 0);
        q1.push_back(mk(5, 2, 2, 0));
        run_event(0, 5, 2, 0);
        tick(12);
        check("rearm_pending", q1.size(), 0);

        // narrow duration counter
        q2.push_back(mk(15, 5, 5, 1));
        run_event(1, 20, 5, 0);
        tick(12);
        q2.push_back(mk(15, 3, 3, 0));
        run_event(1, 15, 3, 0);
        tick(12);
        check("dut2_pending", q2.size(), 0);
        check("dut2_drop_count", int'(drop2), 0);

`ifdef EVSUM_TIMESTAMP_EN
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(99);
        begin
            rec_t r;
            r = mk(4, 7, 7, 0);
            r.ts = 100;
            q1.push_back(r);
        end
        run_event(0, 4, 7, 0);
        tick(12);
        check("ts_pending", q1.size(), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
